// File: rtl/chimera_pkg.sv
// Shared chimera types: APB request/response structs, cluster power-FSM
// state encoding, power-controller register offsets and a byte-strobe helper.
// The optional interrupt feature is enabled by CHIMERA_CLUSTER_PWR_IRQ_EN.
`timescale 1ns/1ps
package chimera_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [2:0] {
    CL_OFF   = 3'd0,
    CL_RESET = 3'd1,
    CL_RUN   = 3'd2,
    CL_ISO   = 3'd3,
    CL_HALT  = 3'd4
  } cluster_pwr_state_e;

  localparam logic [11:0] PWR_ENABLE_OFS     = 12'h000;
  localparam logic [11:0] PWR_ERR_OFS        = 12'h004;
  localparam logic [11:0] PWR_BUSY_OFS       = 12'h008;
  localparam logic [11:0] PWR_IRQ_MASK_OFS   = 12'h00C;
  localparam logic [11:0] PWR_IRQ_PEND_OFS   = 12'h010;
  localparam logic [11:0] PWR_BOOT_ADDR_BASE = 12'h100;
  localparam logic [11:0] PWR_STATE_BASE     = 12'h200;

  // Merge new_val into old_val only in the byte lanes selected by strb.
  function automatic logic [31:0] apb_strb_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// One cluster's power sequencer: OFF -> RESET -> RUN -> ISO -> HALT -> OFF.
// Outputs are a flopped decode of the state, so they trail state by one cycle.
// state_o exposes the current state for register readback and debug.
`timescale 1ns/1ps
module chimera_cluster_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned ResetCycles = 16,
  parameter int unsigned IsoTimeout  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               isolated_i,
  output logic               clk_en_o,
  output logic               rst_o,
  output logic               isolate_o,
  output logic               err_set_o,
  output logic               done_o,
  output cluster_pwr_state_e state_o
);

  localparam int unsigned CntMax = (ResetCycles > IsoTimeout) ? ResetCycles : IsoTimeout;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  cluster_pwr_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic               clk_en_q, rst_q, iso_q;
  logic [2:0]         out_dec;

  // Next-state, counter and timeout-error logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_set_o = 1'b0;
    cnt_inc   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      CL_OFF: begin
        if (enable_i) begin
          state_d = CL_RESET;
          cnt_d   = '0;
        end
      end
      CL_RESET: begin
        if (!enable_i) state_d = CL_OFF;
        else if (cnt_q == CntW'(ResetCycles - 1)) state_d = CL_RUN;
        else cnt_d = cnt_inc;
      end
      CL_RUN: begin
        if (!enable_i) begin
          state_d = CL_ISO;
          cnt_d   = '0;
        end
      end
      CL_ISO: begin
        // A drained cluster beats a timeout landing in the same cycle.
        if (isolated_i) state_d = CL_HALT;
        else if (cnt_q == CntW'(IsoTimeout - 1)) begin
          state_d   = CL_HALT;
          err_set_o = 1'b1;
        end else cnt_d = cnt_inc;
      end
      CL_HALT: state_d = CL_OFF;
      default: state_d = CL_OFF;
    endcase
    done_o = (state_d != state_q) && ((state_d == CL_RUN) || (state_d == CL_OFF));
  end

  // State to {clk_en, rst, isolate} decode, flopped below.
  always_comb begin
    out_dec = 3'b011;
    case (state_q)
      CL_RESET: out_dec = 3'b111;
      CL_RUN:   out_dec = 3'b100;
      CL_ISO:   out_dec = 3'b101;
      CL_HALT:  out_dec = 3'b111;
      default:  out_dec = 3'b011;
    endcase
  end

  // State, counter and registered cluster controls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CL_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      rst_q    <= 1'b1;
      iso_q    <= 1'b1;
    end else begin
      state_q                    <= state_d;
      cnt_q                      <= cnt_d;
      {clk_en_q, rst_q, iso_q}   <= out_dec;
    end
  end

  assign clk_en_o  = clk_en_q;
  assign rst_o     = rst_q;
  assign isolate_o = iso_q;
  assign state_o   = state_q;

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// APB power/reset sequencer for the external clusters. Holds ENABLE, ERR,
// BOOT_ADDR (and IRQ registers when CHIMERA_CLUSTER_PWR_IRQ_EN is defined)
// and runs one chimera_cluster_pwr_fsm per cluster.
// APB handshake: zero wait state; pready is high in every access phase
// (psel & penable), prdata/pslverr are valid in that same cycle, and a write
// commits on the clock edge that ends the access phase.
`timescale 1ns/1ps
module chimera_cluster_pwr_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned ResetCycles = 16,
  parameter int unsigned IsoTimeout  = 1024,
  parameter logic [31:0] BootAddrRst = 32'h3000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  apb_req_t                    apb_req_i,
  output apb_resp_t                   apb_rsp_o,
  output logic [NumClusters-1:0]      clk_en_o,
  output logic [NumClusters-1:0]      rst_o,
  output logic [NumClusters-1:0]      isolate_o,
  input  logic [NumClusters-1:0]      isolated_i,
  output logic [NumClusters-1:0][31:0] boot_addr_o
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
  ,
  output logic                        irq_o
`endif
);

  logic [NumClusters-1:0]       enable_q, enable_d, err_q, err_clr, err_set, done, busy;
  logic [NumClusters-1:0][31:0] boot_q, boot_d;
  cluster_pwr_state_e           state [NumClusters];
  logic                         access, wr, slverr, sel_ok;
  logic [11:0]                  ofs;
  logic [5:0]                   idx;
  logic [31:0]                  rdata, sel_boot;
  cluster_pwr_state_e           sel_state;
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
  logic [NumClusters-1:0]       mask_q, mask_d, pend_q, pend_clr;
  logic                         irq_q;
`else
  logic                         unused_done;
  assign unused_done = ^done;
`endif
  logic                         unused_addr;
  assign unused_addr = ^apb_req_i.paddr[31:12];

  for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
    chimera_cluster_pwr_fsm #(
      .ResetCycles (ResetCycles),
      .IsoTimeout  (IsoTimeout)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_q[g]),
      .isolated_i (isolated_i[g]),
      .clk_en_o   (clk_en_o[g]),
      .rst_o      (rst_o[g]),
      .isolate_o  (isolate_o[g]),
      .err_set_o  (err_set[g]),
      .done_o     (done[g]),
      .state_o    (state[g])
    );
  end

  // Busy means mid-sequence: neither parked OFF nor steady RUN.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NumClusters; i++) begin
      busy[i] = (state[i] != CL_OFF) && (state[i] != CL_RUN);
    end
  end

  // APB decode: read mux, write enables and slave error.
  always_comb begin
    access    = apb_req_i.psel & apb_req_i.penable;
    wr        = access & apb_req_i.pwrite;
    ofs       = apb_req_i.paddr[11:0];
    idx       = ofs[7:2];
    rdata     = '0;
    slverr    = 1'b0;
    enable_d  = enable_q;
    boot_d    = boot_q;
    err_clr   = '0;
    sel_ok    = 1'b0;
    sel_boot  = '0;
    sel_state = CL_OFF;
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
    mask_d    = mask_q;
    pend_clr  = '0;
`endif
    for (int i = 0; i < NumClusters; i++) begin
      if (int'(idx) == i) begin
        sel_ok    = 1'b1;
        sel_boot  = boot_q[i];
        sel_state = state[i];
      end
    end
    if (access) begin
      if (ofs == PWR_ENABLE_OFS) begin
        rdata[NumClusters-1:0] = enable_q;
        if (wr) begin
          for (int i = 0; i < NumClusters; i++) begin
            enable_d[i] = apb_req_i.pstrb[i/8] ? apb_req_i.pwdata[i] : enable_q[i];
          end
        end
      end else if (ofs == PWR_ERR_OFS) begin
        rdata[NumClusters-1:0] = err_q;
        if (wr) begin
          for (int i = 0; i < NumClusters; i++) begin
            err_clr[i] = apb_req_i.pstrb[i/8] & apb_req_i.pwdata[i];
          end
        end
      end else if (ofs == PWR_BUSY_OFS) begin
        rdata[NumClusters-1:0] = busy;
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
      end else if (ofs == PWR_IRQ_MASK_OFS) begin
        rdata[NumClusters-1:0] = mask_q;
        if (wr) begin
          for (int i = 0; i < NumClusters; i++) begin
            mask_d[i] = apb_req_i.pstrb[i/8] ? apb_req_i.pwdata[i] : mask_q[i];
          end
        end
      end else if (ofs == PWR_IRQ_PEND_OFS) begin
        rdata[NumClusters-1:0] = pend_q;
        if (wr) begin
          for (int i = 0; i < NumClusters; i++) begin
            pend_clr[i] = apb_req_i.pstrb[i/8] & apb_req_i.pwdata[i];
          end
        end
`endif
      end else if (((ofs & 12'hF00) == PWR_BOOT_ADDR_BASE) && sel_ok) begin
        rdata = sel_boot;
        if (wr) begin
          // Boot address may only change while the cluster is fully off.
          if (sel_state != CL_OFF) slverr = 1'b1;
          else begin
            for (int i = 0; i < NumClusters; i++) begin
              if (int'(idx) == i) begin
                boot_d[i] = apb_strb_merge(boot_q[i], apb_req_i.pwdata, apb_req_i.pstrb);
              end
            end
          end
        end
      end else if (((ofs & 12'hF00) == PWR_STATE_BASE) && sel_ok) begin
        rdata = {29'b0, sel_state};
      end else begin
        slverr = 1'b1;
      end
      if (slverr) rdata = '0;
    end
  end

  // Shared registers; a new timeout beats a same-cycle ERR clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= '0;
      err_q    <= '0;
      boot_q   <= {NumClusters{BootAddrRst}};
    end else begin
      enable_q <= enable_d;
      err_q    <= (err_q & ~err_clr) | err_set;
      boot_q   <= boot_d;
    end
  end

`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
  // Interrupt mask, sticky done-event pending bits and registered irq.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      pend_q <= (pend_q & ~pend_clr) | done;
      irq_q  <= |(pend_q & mask_q);
    end
  end

  assign irq_o = irq_q;
`endif

  assign apb_rsp_o.pready  = access;
  assign apb_rsp_o.prdata  = rdata;
  assign apb_rsp_o.pslverr = slverr;
  assign boot_addr_o       = boot_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Directed + randomized bench for chimera_cluster_pwr_ctrl. Expected timing
// comes from closed-form sequence lengths (latency, reset length, isolation
// delay clipped at the timeout) and a register-file model of the APB map.
// Build with CHIMERA_CLUSTER_PWR_IRQ_EN to also exercise irq_o.
`timescale 1ns/1ps
module tb_chimera_cluster_pwr_ctrl;
  import chimera_pkg::*;

  localparam int          N        = 5;
  localparam int          RC       = 16;
  localparam int          IT       = 1024;
  localparam logic [31:0] BOOT_RST = 32'h3000_0000;
  localparam logic [31:0] BASE     = 32'h3000_1000;
  localparam int          NEVER    = 32'h7fff_ffff;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  apb_req_t              req;
  apb_resp_t             rsp;
  logic [N-1:0]          clk_en, rst_c, iso;
  logic [N-1:0]          isolated;
  logic [N-1:0][31:0]    boot;
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
  logic                  irq;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] boot_m [N];
  logic [N-1:0] en_m, err_m;
  logic [31:0] exp_q [$];

  chimera_cluster_pwr_ctrl #(
    .NumClusters (N),
    .ResetCycles (RC),
    .IsoTimeout  (IT),
    .BootAddrRst (BOOT_RST)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .apb_req_i   (req),
    .apb_rsp_o   (rsp),
    .clk_en_o    (clk_en),
    .rst_o       (rst_c),
    .isolate_o   (iso),
    .isolated_i  (isolated),
    .boot_addr_o (boot)
`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] ofs, input logic [31:0] d, input logic [3:0] s,
                        output logic err);
    req.paddr   = BASE | {20'b0, ofs};
    req.pwrite  = 1'b1;
    req.pwdata  = d;
    req.pstrb   = s;
    req.psel    = 1'b1;
    req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    #1;
    check("pready_wr", rsp.pready, 1'b1);
    err = rsp.pslverr;
    @(posedge clk); #1;
    req.psel    = 1'b0;
    req.penable = 1'b0;
    req.pwrite  = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] ofs, output logic [31:0] d, output logic err);
    req.paddr   = BASE | {20'b0, ofs};
    req.pwrite  = 1'b0;
    req.pwdata  = '0;
    req.pstrb   = '0;
    req.psel    = 1'b1;
    req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    #1;
    check("pready_rd", rsp.pready, 1'b1);
    d   = rsp.prdata;
    err = rsp.pslverr;
    @(posedge clk); #1;
    req.psel    = 1'b0;
    req.penable = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Turn cluster c on and measure the start-up sequence.
  task automatic cluster_up(input int c);
    logic        e;
    logic [31:0] d;
    int          lat, n;
    en_m[c] = 1'b1;
    apb_wr(PWR_ENABLE_OFS, 32'(en_m), 4'hF, e);
    check("up_wr_err", e, 1'b0);
    lat = 0;
    while (clk_en[c] !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("up_latency", lat, 2);
    n = 0;
    while (rst_c[c] === 1'b1 && clk_en[c] === 1'b1 && n < 4 * RC) begin
      n++;
      @(posedge clk); #1;
    end
    check("up_reset_len", n, RC);
    check("up_run_outs", {clk_en[c], rst_c[c], iso[c]}, 3'b100);
    apb_rd(PWR_STATE_BASE + 12'(4 * c), d, e);
    check("up_state_run", d, 32'd2);
  endtask

  // Turn cluster c off; isolated_i rises k cycles after the write (NEVER = never).
  task automatic cluster_down(input int c, input int k);
    logic        e;
    logic [31:0] d;
    int          n, halt, k_eff;
    en_m[c] = 1'b0;
    apb_wr(PWR_ENABLE_OFS, 32'(en_m), 4'hF, e);
    check("down_wr_err", e, 1'b0);
    n    = 0;
    halt = 0;
    while (clk_en[c] === 1'b1 && n < IT + 20) begin
      if (n == k) isolated[c] = 1'b1;
      @(posedge clk); #1;
      n++;
      if (rst_c[c] === 1'b1 && clk_en[c] === 1'b1) halt++;
    end
    isolated[c] = 1'b0;
    if (k > IT) err_m[c] = 1'b1;
    k_eff = (k < IT) ? k : IT;
    check("down_len", n, k_eff + 3);
    check("down_halt_cycles", halt, 1);
    check("down_off_outs", {clk_en[c], rst_c[c], iso[c]}, 3'b011);
    apb_rd(PWR_ERR_OFS, d, e);
    check("down_err_reg", d, 32'(err_m));
    apb_rd(PWR_STATE_BASE + 12'(4 * c), d, e);
    check("down_state_off", d, 32'd0);
  endtask

  initial begin
    logic        e;
    logic [31:0] d;
    logic [3:0]  s;
    int          c, k;

    req      = '0;
    isolated = '0;
    en_m     = '0;
    err_m    = '0;
    for (int i = 0; i < N; i++) boot_m[i] = BOOT_RST;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_en", clk_en, '0);
    check("rst_rst", rst_c, {N{1'b1}});
    check("rst_iso", iso, {N{1'b1}});
    check("rst_pready", rsp.pready, 1'b0);
    rst = 1'b0;
    cycles(1);
    for (int i = 0; i < N; i++) begin
      check("rst_boot_out", boot[i], BOOT_RST);
      apb_rd(PWR_STATE_BASE + 12'(4 * i), d, e);
      check("rst_state", d, 32'd0);
      check("rst_state_err", e, 1'b0);
    end
    apb_rd(PWR_ENABLE_OFS, d, e);
    check("rst_enable", d, 32'd0);
    apb_rd(PWR_ERR_OFS, d, e);
    check("rst_err", d, 32'd0);
    apb_rd(PWR_BUSY_OFS, d, e);
    check("rst_busy", d, 32'd0);

    // Unmapped offsets and out-of-range cluster indices.
    apb_rd(12'h300, d, e);
    check("unmapped_err", e, 1'b1);
    check("unmapped_data", d, 32'd0);
    apb_rd(PWR_BOOT_ADDR_BASE + 12'(4 * N), d, e);
    check("boot_oor_err", e, 1'b1);
    apb_rd(PWR_STATE_BASE + 12'(4 * N), d, e);
    check("state_oor_err", e, 1'b1);
    apb_wr(PWR_BOOT_ADDR_BASE + 12'(4 * N), 32'hDEAD_BEEF, 4'hF, e);
    check("boot_oor_wr_err", e, 1'b1);
`ifndef CHIMERA_CLUSTER_PWR_IRQ_EN
    apb_rd(PWR_IRQ_MASK_OFS, d, e);
    check("irq_mask_unmapped", e, 1'b1);
    apb_rd(PWR_IRQ_PEND_OFS, d, e);
    check("irq_pend_unmapped", e, 1'b1);
`endif

    // A write with no byte strobes must not enable anything.
    apb_wr(PWR_ENABLE_OFS, 32'h1F, 4'h0, e);
    cycles(3);
    apb_rd(PWR_ENABLE_OFS, d, e);
    check("enable_nostrb", d, 32'd0);
    check("enable_nostrb_clk", clk_en, '0);

    // Cluster 0 up, then down with isolation 5 cycles later.
    cluster_up(0);
    apb_rd(PWR_BUSY_OFS, d, e);
    check("busy_run", d, 32'd0);
    cluster_down(0, 5);

    // Cluster 2 down with no isolation: timeout, then w1c.
    cluster_up(2);
    cluster_down(2, NEVER);
    apb_wr(PWR_ERR_OFS, 32'h04, 4'hF, e);
    err_m[2] = 1'b0;
    apb_rd(PWR_ERR_OFS, d, e);
    check("err_w1c", d, 32'(err_m));

    // Isolation arriving on the very last timeout cycle: no error.
    cluster_up(3);
    cluster_down(3, IT);

    // Boot address locked while running, accepted while off.
    cluster_up(1);
    apb_wr(PWR_BOOT_ADDR_BASE + 12'd4, 32'h3000_0800, 4'hF, e);
    check("boot_run_err", e, 1'b1);
    apb_rd(PWR_BOOT_ADDR_BASE + 12'd4, d, e);
    check("boot_run_keep", d, boot_m[1]);
    check("boot_run_out", boot[1], boot_m[1]);
    cluster_down(1, int'($urandom_range(1, 40)));
    apb_wr(PWR_BOOT_ADDR_BASE + 12'd4, 32'h3000_0800, 4'hF, e);
    boot_m[1] = 32'h3000_0800;
    check("boot_off_err", e, 1'b0);
    check("boot_off_out", boot[1], boot_m[1]);

    // Random byte-strobed boot address writes on idle clusters.
    repeat (8) begin
      c = int'($urandom_range(0, N - 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) begin
        if (s[b]) boot_m[c][8*b +: 8] = d[8*b +: 8];
      end
      exp_q.push_back(boot_m[c]);
      apb_wr(PWR_BOOT_ADDR_BASE + 12'(4 * c), d, s, e);
      check("rand_boot_wr_err", e, 1'b0);
      apb_rd(PWR_BOOT_ADDR_BASE + 12'(4 * c), d, e);
      check("rand_boot_rd", d, exp_q.pop_front());
      check("rand_boot_out", boot[c], boot_m[c]);
    end

    // Random up/down cycles with random isolation delays.
    repeat (3) begin
      c = int'($urandom_range(0, N - 1));
      k = int'($urandom_range(1, 60));
      cluster_up(c);
      cycles(int'($urandom_range(0, 10)));
      cluster_down(c, k);
    end

    // Reset asserted while every cluster is in its reset phase.
    en_m = {N{1'b1}};
    apb_wr(PWR_ENABLE_OFS, 32'(en_m), 4'hF, e);
    apb_rd(PWR_BUSY_OFS, d, e);
    check("busy_all_reset", d, 32'(en_m));
    cycles(3);
    check("mid_reset_clk_en", clk_en, {N{1'b1}});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_clk_en", clk_en, '0);
    check("rst_mid_rst", rst_c, {N{1'b1}});
    check("rst_mid_iso", iso, {N{1'b1}});
    en_m  = '0;
    err_m = '0;
    for (int i = 0; i < N; i++) boot_m[i] = BOOT_RST;
    apb_rd(PWR_ENABLE_OFS, d, e);
    check("rst_mid_enable", d, 32'd0);
    for (int i = 0; i < N; i++) begin
      apb_rd(PWR_STATE_BASE + 12'(4 * i), d, e);
      check("rst_mid_state", d, 32'd0);
      check("rst_mid_boot", boot[i], boot_m[i]);
    end

`ifdef CHIMERA_CLUSTER_PWR_IRQ_EN
    // Interrupt on RUN entry of an unmasked cluster.
    apb_wr(PWR_IRQ_MASK_OFS, 32'h1, 4'hF, e);
    check("irq_mask_wr_err", e, 1'b0);
    check("irq_idle", irq, 1'b0);
    cluster_up(0);
    check("irq_on_run", irq, 1'b1);
    apb_rd(PWR_IRQ_PEND_OFS, d, e);
    check("irq_pend", d, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
